// File: rtl/regfile_bypass.sv
// ---------------------------------------------------------------------------
// regfile_bypass
//
// Parametrised register file for the processor datapath: two combinational
// read ports and one synchronous write port. Register 0 can optionally be
// hardwired to zero. Reads can optionally see the write being presented in
// the same cycle.
//
// Parameters
//   WIDTH    : data bits per register
//   DEPTH    : number of registers (must be <= 2**AW)
//   AW       : address width of every address port
//   ZERO_REG : 1 = register 0 reads as zero and ignores writes
//   BYPASS   : 1 = a read of the address being written returns wdata
//
// Ports
//   clock    : rising-edge clock
//   reset    : synchronous, active-high; clears every register
//   we       : write enable, sampled on the rising edge
//   waddr    : write address
//   wdata    : write data
//   raddr_a  : read port A address
//   raddr_b  : read port B address
//   rdata_a  : read port A data (combinational)
//   rdata_b  : read port B data (combinational)
// ---------------------------------------------------------------------------
module regfile_bypass #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b
);

    // One extra bit so that DEPTH == 2**AW is still representable.
    localparam logic [AW:0] DEPTH_LIM = (AW + 1)'(DEPTH);

    // -----------------------------------------------------------------------
    // Write qualification
    // -----------------------------------------------------------------------
    logic waddr_in_range;
    logic waddr_is_zero;
    logic write_legal;

    assign waddr_in_range = ({1'b0, waddr} < DEPTH_LIM);
    assign waddr_is_zero  = (waddr == '0);

    // A single qualified strobe drives both the storage update and the
    // bypass path, so an ignored write can never be forwarded and nothing
    // is forwarded while reset is held.
    assign write_legal = we && !reset && waddr_in_range
                         && !((ZERO_REG != 0) && waddr_is_zero);

    // -----------------------------------------------------------------------
    // Storage: one flop bank per register
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] mem [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
        if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
            // Hardwired zero: no storage at all.
            assign mem[gi] = '0;
        end else begin : g_flop
            logic [WIDTH-1:0] q_reg;

            always_ff @(posedge clock) begin
                if (reset) begin
                    q_reg <= '0;
                end else if (write_legal && (waddr == AW'(gi))) begin
                    q_reg <= wdata;
                end
            end

            assign mem[gi] = q_reg;
        end
    end

    // -----------------------------------------------------------------------
    // Read ports
    // -----------------------------------------------------------------------
    logic [AW-1:0]    raddr [2];
    logic [WIDTH-1:0] rdata [2];

    assign raddr[0] = raddr_a;
    assign raddr[1] = raddr_b;
    assign rdata_a  = rdata[0];
    assign rdata_b  = rdata[1];

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic [WIDTH-1:0] stored;
        logic             hit_zero;
        logic             hit_bypass;

        // Full-address decode over the implemented registers only: an
        // address at or above DEPTH matches nothing and falls through to
        // zero, and no address bits are ever dropped, so there is no
        // aliasing onto a real register.
        always_comb begin
            stored = '0;
            for (int i = 0; i < DEPTH; i++) begin
                if (raddr[gi] == AW'(i)) begin
                    stored = mem[i];
                end
            end
        end

        assign hit_zero   = (ZERO_REG != 0) && (raddr[gi] == '0);
        assign hit_bypass = (BYPASS != 0) && write_legal
                            && (raddr[gi] == waddr);

        // Hardwired zero wins over bypass; bypass wins over storage.
        always_comb begin
            if (hit_zero) begin
                rdata[gi] = '0;
            end else if (hit_bypass) begin
                rdata[gi] = wdata;
            end else begin
                rdata[gi] = stored;
            end
        end
    end

endmodule

// File: tb/tb_regfile_bypass.sv
// ---------------------------------------------------------------------------
// tb_regfile_bypass
//
// Directed bench for regfile_bypass. Three instances are exercised:
//   u_main  : defaults (32x32, ZERO_REG=1, BYPASS=1), driven from a table
//   u_nobyp : BYPASS=0, ZERO_REG=0, hand-written sequence
//   u_d24   : DEPTH=24, AW=5, range checks and a full register sweep
// Reset is shared; each instance has its own write/read inputs and is idle
// (we=0) while another instance is being exercised.
// ---------------------------------------------------------------------------
module tb_regfile_bypass;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic        m_we = 1'b0, n_we = 1'b0, d_we = 1'b0;
    logic [4:0]  m_wa = '0, m_ra = '0, m_rb = '0;
    logic [4:0]  n_wa = '0, n_ra = '0, n_rb = '0;
    logic [4:0]  d_wa = '0, d_ra = '0, d_rb = '0;
    logic [31:0] m_wd = '0, n_wd = '0, d_wd = '0;
    logic [31:0] m_a, m_b, n_a, n_b, d_a, d_b;

    regfile_bypass u_main (
        .clock(clk), .reset(rst), .we(m_we), .waddr(m_wa), .wdata(m_wd),
        .raddr_a(m_ra), .raddr_b(m_rb), .rdata_a(m_a), .rdata_b(m_b)
    );

    regfile_bypass #(.ZERO_REG(0), .BYPASS(0)) u_nobyp (
        .clock(clk), .reset(rst), .we(n_we), .waddr(n_wa), .wdata(n_wd),
        .raddr_a(n_ra), .raddr_b(n_rb), .rdata_a(n_a), .rdata_b(n_b)
    );

    regfile_bypass #(.DEPTH(24), .AW(5)) u_d24 (
        .clock(clk), .reset(rst), .we(d_we), .waddr(d_wa), .wdata(d_wd),
        .raddr_a(d_ra), .raddr_b(d_rb), .rdata_a(d_a), .rdata_b(d_b)
    );

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic        r;
        logic        w;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] ea;
        logic [31:0] eb;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic r, input logic w,
                                input logic [4:0] wa, input logic [31:0] wd,
                                input logic [4:0] ra, input logic [4:0] rb,
                                input logic [31:0] ea, input logic [31:0] eb);
        vec_t v;
        v.r = r; v.w = w; v.wa = wa; v.wd = wd;
        v.ra = ra; v.rb = rb; v.ea = ea; v.eb = eb;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %08h, expected %08h", name, got, exp);
        end
    endtask

    // One clock cycle: drive after the rising edge, compare the
    // combinational outputs at the falling edge, before the write commits.
    task automatic cycle(input int sel, input logic r, input logic w,
                         input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra, input logic [4:0] rb,
                         input logic [31:0] ea, input logic [31:0] eb,
                         input string name);
        logic [31:0] ga, gb;
        @(posedge clk);
        #1;
        rst  = r;
        m_we = 1'b0;
        n_we = 1'b0;
        d_we = 1'b0;
        case (sel)
            0: begin m_we = w; m_wa = wa; m_wd = wd; m_ra = ra; m_rb = rb; end
            1: begin n_we = w; n_wa = wa; n_wd = wd; n_ra = ra; n_rb = rb; end
            default: begin d_we = w; d_wa = wa; d_wd = wd; d_ra = ra; d_rb = rb; end
        endcase
        @(negedge clk);
        case (sel)
            0:       begin ga = m_a; gb = m_b; end
            1:       begin ga = n_a; gb = n_b; end
            default: begin ga = d_a; gb = d_b; end
        endcase
        $display("[TB] %s inst=%0d rst=%0b we=%0b wa=%0d wd=%08h ra=%0d rb=%0d -> a=%08h b=%08h",
                 name, sel, r, w, wa, wd, ra, rb, ga, gb);
        check({name, "_a"}, ga, ea);
        check({name, "_b"}, gb, eb);
    endtask

    initial begin
        // Table for the default instance; register state assumed all-zero
        // after the initial reset.
        vecs[0]  = mk(0, 0, 5'd0,  32'h0,        5'd5,  5'd31, 32'h0,        32'h0);
        vecs[1]  = mk(0, 1, 5'd7,  32'hDEADBEEF, 5'd7,  5'd0,  32'hDEADBEEF, 32'h0);
        vecs[2]  = mk(0, 0, 5'd0,  32'h0,        5'd7,  5'd7,  32'hDEADBEEF, 32'hDEADBEEF);
        vecs[3]  = mk(0, 1, 5'd0,  32'h12345678, 5'd0,  5'd7,  32'h0,        32'hDEADBEEF);
        vecs[4]  = mk(0, 0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0);
        vecs[5]  = mk(0, 1, 5'd3,  32'h11,       5'd3,  5'd7,  32'h11,       32'hDEADBEEF);
        vecs[6]  = mk(0, 1, 5'd3,  32'h22,       5'd3,  5'd3,  32'h22,       32'h22);
        vecs[7]  = mk(0, 0, 5'd0,  32'h0,        5'd3,  5'd3,  32'h22,       32'h22);
        // Reset with a simultaneous write: r4 not forwarded, r3 still old.
        vecs[8]  = mk(1, 1, 5'd4,  32'hFF,       5'd4,  5'd3,  32'h0,        32'h22);
        vecs[9]  = mk(0, 0, 5'd0,  32'h0,        5'd4,  5'd3,  32'h0,        32'h0);
        vecs[10] = mk(0, 1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd30, 32'hA5A5A5A5, 32'h0);
        vecs[11] = mk(0, 0, 5'd0,  32'h0,        5'd31, 5'd7,  32'hA5A5A5A5, 32'h0);
        vecs[12] = mk(0, 1, 5'd5,  32'hCAFEF00D, 5'd6,  5'd5,  32'h0,        32'hCAFEF00D);
        vecs[13] = mk(0, 0, 5'd0,  32'h0,        5'd5,  5'd6,  32'hCAFEF00D, 32'h0);

        rst = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < NVEC; i++) begin
            cycle(0, vecs[i].r, vecs[i].w, vecs[i].wa, vecs[i].wd,
                  vecs[i].ra, vecs[i].rb, vecs[i].ea, vecs[i].eb,
                  $sformatf("main_v%0d", i));
        end

        // BYPASS=0, ZERO_REG=0: reads show the old value during the write.
        cycle(1, 0, 1, 5'd3, 32'h11,       5'd3, 5'd3, 32'h0,        32'h0,        "nb_w11");
        cycle(1, 0, 1, 5'd3, 32'h22,       5'd3, 5'd3, 32'h11,       32'h11,       "nb_w22");
        cycle(1, 0, 0, 5'd0, 32'h0,        5'd3, 5'd3, 32'h22,       32'h22,       "nb_rd22");
        cycle(1, 0, 1, 5'd0, 32'h12345678, 5'd0, 5'd3, 32'h0,        32'h22,       "nb_wr0");
        cycle(1, 0, 0, 5'd0, 32'h0,        5'd0, 5'd0, 32'h12345678, 32'h12345678, "nb_rd0");

        // DEPTH=24: out-of-range writes are dropped and never forwarded.
        cycle(2, 0, 1, 5'd1,  32'h5A, 5'd1,  5'd25, 32'h5A, 32'h0,  "d24_w1");
        cycle(2, 0, 1, 5'd25, 32'hAB, 5'd25, 5'd1,  32'h0,  32'h5A, "d24_w25");
        cycle(2, 0, 0, 5'd0,  32'h0,  5'd25, 5'd1,  32'h0,  32'h5A, "d24_rd25");
        cycle(2, 0, 1, 5'd24, 32'h77, 5'd24, 5'd23, 32'h0,  32'h0,  "d24_w24");
        cycle(2, 0, 0, 5'd0,  32'h0,  5'd24, 5'd1,  32'h0,  32'h5A, "d24_rd24");

        // Sweep every register with write-then-read of addr*0x01010101.
        for (int a = 0; a < 24; a++) begin
            logic [31:0] pat;
            logic [31:0] exp;
            pat = 32'(a) * 32'h01010101;
            exp = (a == 0) ? 32'h0 : pat;
            cycle(2, 0, 1, 5'(a), pat,   5'(a), 5'd25, exp, 32'h0, $sformatf("sweep_w%0d", a));
            cycle(2, 0, 0, 5'd0,  32'h0, 5'(a), 5'(a), exp, exp,   $sformatf("sweep_r%0d", a));
        end

        // Final readback of the whole file on both ports.
        for (int a = 0; a < 24; a++) begin
            logic [31:0] ea;
            logic [31:0] eb;
            ea = (a == 0) ? 32'h0 : 32'(a) * 32'h01010101;
            eb = (a == 23) ? 32'h0 : 32'(23 - a) * 32'h01010101;
            cycle(2, 0, 0, 5'd0, 32'h0, 5'(a), 5'(23 - a), ea, eb,
                  $sformatf("final_r%0d", a));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
